rtc_bcd_counter: RTL and testbench
==================================

# rtc_bcd_counter

- Parametrised successor to the minute-only clock counting logic.
- Keeps a BCD hours/minutes(/seconds) time of day and advances it on qualified tick pulses through a programmable prescaler.
- Supports runtime 12/24-hour mode with automatic hour conversion, validated loads, and rollover strobes.
- Sits between the tick generator and the display/alarm logic of the clock subsystem.

## Interface
Parameters:
- PRESCALE, 1: tick pulses per counted unit (second, or minute without seconds); legal range 1..65535.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- tick  in  1  single-cycle qualified time pulse.
- mode_24h  in  1  1 = 24-hour, 0 = 12-hour; sampled every cycle.
- load  in  1  single-cycle request to load the load_* fields.
- load_sec_ls, load_sec_ms, load_min_ls, load_min_ms, load_hr_ls, load_hr_ms  in  4 each  BCD load values.
- load_pm  in  1  PM flag for a 12-hour load; ignored in 24-hour mode.
- sec_ls, sec_ms, min_ls, min_ms, hr_ls, hr_ms  out  4 each  current BCD time.
- pm  out  1  12-hour mode: PM flag; 24-hour mode: 1 when hour >= 12.
- load_err  out  1  one-cycle pulse, load rejected.
- min_pulse, hour_pulse, day_pulse  out  1  one-cycle rollover strobes.

## Operation
- Prescaler counts tick pulses 0..PRESCALE-1. The advance fires on the tick that wraps it; width is clog2(PRESCALE), minimum 1 bit.
- Advance chain:
  - sec 00..59
  - then min 00..59
  - then hour: 24 h 00..23; 12 h 12,01..11 with pm toggling on 11:59:59 -> 12:00:00.
- Strobes:
  - min_pulse: seconds 59 -> 00.
  - hour_pulse: minutes 59 -> 00.
  - day_pulse: 23:59:59 -> 00:00:00, or 11:59:59 PM -> 12:00:00 AM.
  - Strobes are registered and high in the same cycle the new time appears.
- Load validation: minutes and seconds 00..59, every digit 0..9, hours 00..23 (24 h) or 01..12 (12 h), judged against the current registered mode.
  - Valid load: all fields update and the prescaler clears.
  - Invalid load: no field changes; load_err is high the following cycle.
- Mode conversion: when mode_24h differs from the internal registered mode, the hour is converted in one cycle and the mode register updates.
  - 12 -> 24 h: 12 AM -> 00, 1-11 AM unchanged, 12 PM -> 12, 1-11 PM -> +12.
  - 24 -> 12 h: the inverse mapping; pm is set for hours 12..23.
  - Minutes and seconds are untouched.
- Priority per cycle: load > mode conversion > advance.
  - Tick with load: the tick is discarded.
  - Advance with conversion: the advance is held in a pending flag and applied the next cycle, so no count is lost.
  - Only one pending advance is stored.
- Reset values: all digits 0, pm 0, load_err 0, all strobes 0, prescaler 0, pending 0, internal mode 24 h.
  - When mode_24h is low, the following cycle converts 00:00:00 to 12:00:00 AM.

## Timing
- Tick-to-output latency: 1 clock. For PRESCALE = 1, a tick sampled at edge N gives the new time after edge N.
- Load-to-output and load-to-load_err latency: 1 clock.
- Mode change: hour converted 1 clock after mode_24h changes; a held advance lands 1 clock later.
- Minimum tick spacing: 2 clocks, so a pending advance always drains. Back-to-back ticks are defined only when no mode change occurs.
- Reset assertion clears state immediately, mid-advance or mid-load, with no partial update. Deassertion is synchronised externally.

## Configuration
- RTC_BCD_COUNTER_SECONDS_EN defined:
  - The seconds stage is present.
  - The prescaler advances seconds; load_sec_* are validated and loaded.
- Not defined:
  - The seconds stage is absent; the prescaler advances minutes directly.
  - sec_ls and sec_ms are tied to 0 and load_sec_* are ignored.
  - min_pulse fires on every advance.

## Test plan
- Reset low, mode_24h = 1, PRESCALE = 1 -> 00:00:00, pm 0. Then 60 ticks -> 00:01:00 with min_pulse on the 60th tick.
- 12 h mode, load 11:59:59 AM, one tick -> 12:00:00 PM with min_pulse and hour_pulse. Load 11:59:59 PM, one tick -> 12:00:00 AM with day_pulse.
- 24 h mode, load 23:59:59, one tick -> 00:00:00, day_pulse high, pm 0.
- Load 12:75:00, or hour 13 in 12 h mode -> time unchanged, load_err pulses once the next cycle.
- Time 15:30:00 in 24 h mode, mode_24h drops while a tick advances the prescaler to wrap -> 03:30:00 PM, then 03:30:01 one cycle later.
- PRESCALE = 4: 8 ticks -> seconds +2. A load coinciding with the 4th tick clears the prescaler and drops that tick.

Source files
------------

// File: rtl/rtc_bcd_counter.sv
// BCD time-of-day counter: prescaled tick advance, runtime 12/24-hour conversion, validated loads.
// Optional seconds stage enabled by defining RTC_BCD_COUNTER_SECONDS_EN.
module rtc_bcd_counter #(
    parameter int PRESCALE = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tick,
    input  logic       mode_24h,
    input  logic       load,
    input  logic [3:0] load_sec_ls,
    input  logic [3:0] load_sec_ms,
    input  logic [3:0] load_min_ls,
    input  logic [3:0] load_min_ms,
    input  logic [3:0] load_hr_ls,
    input  logic [3:0] load_hr_ms,
    input  logic       load_pm,
    output logic [3:0] sec_ls,
    output logic [3:0] sec_ms,
    output logic [3:0] min_ls,
    output logic [3:0] min_ms,
    output logic [3:0] hr_ls,
    output logic [3:0] hr_ms,
    output logic       pm,
    output logic       load_err,
    output logic       min_pulse,
    output logic       hour_pulse,
    output logic       day_pulse
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

    function automatic logic [7:0] bcd2bin(input logic [3:0] ms, input logic [3:0] ls);
        return ({4'd0, ms} * 8'd10) + {4'd0, ls};
    endfunction

    function automatic logic [7:0] bin2bcd(input logic [4:0] v);
        logic [4:0] tens;
        tens = v / 5'd10;
        return {4'(tens), 4'(v - tens * 5'd10)};
    endfunction

    function automatic logic [4:0] to_12h(input logic [4:0] h24);
        if (h24 == 5'd0)
            return 5'd12;
        else if (h24 > 5'd12)
            return h24 - 5'd12;
        else
            return h24;
    endfunction

    function automatic logic [4:0] to_24h(input logic [4:0] h12, input logic is_pm);
        if (h12 == 5'd12)
            return is_pm ? 5'd12 : 5'd0;
        else
            return is_pm ? h12 + 5'd12 : h12;
    endfunction

    logic [PW-1:0] presc;
    logic          pending;
    logic          mode_r;
    logic [3:0]    sec_ls_q, sec_ms_q;

    logic [4:0]    hr_now, nxt_hr, cv_hr;
    logic [3:0]    nxt_sec_ls, nxt_sec_ms, nxt_min_ls, nxt_min_ms;
    logic          nxt_pm, carry_min, carry_hr, day_roll;
    logic          presc_wrap;
    logic [PW-1:0] presc_nxt;
    logic [7:0]    ld_hr;
    logic          ld_ok, ld_pm;

    assign hr_now = 5'(bcd2bin(hr_ms, hr_ls));
    assign cv_hr  = mode_r ? to_12h(hr_now) : to_24h(hr_now, pm);

    assign presc_wrap = tick && (presc == PRESC_LAST);
    assign presc_nxt  = !tick ? presc : (presc_wrap ? '0 : presc + PW'(1));

`ifdef RTC_BCD_COUNTER_SECONDS_EN
    assign sec_ls = sec_ls_q;
    assign sec_ms = sec_ms_q;
`else
    logic unused_load_sec;
    assign sec_ls = 4'd0;
    assign sec_ms = 4'd0;
    assign unused_load_sec = ^{load_sec_ls, load_sec_ms};
`endif

    always_comb begin
        ld_hr = bcd2bin(load_hr_ms, load_hr_ls);
        ld_ok = (load_hr_ms <= 4'd9) && (load_hr_ls <= 4'd9) &&
                (load_min_ms <= 4'd5) && (load_min_ls <= 4'd9) &&
                (mode_r ? (ld_hr <= 8'd23) : (ld_hr >= 8'd1 && ld_hr <= 8'd12));
`ifdef RTC_BCD_COUNTER_SECONDS_EN
        ld_ok = ld_ok && (load_sec_ms <= 4'd5) && (load_sec_ls <= 4'd9);
`endif
        ld_pm = mode_r ? (ld_hr >= 8'd12) : load_pm;
    end

    // Next time of day for one advance; carries ripple seconds -> minutes -> hours
    always_comb begin
        nxt_sec_ls = sec_ls_q;
        nxt_sec_ms = sec_ms_q;
        nxt_min_ls = min_ls;
        nxt_min_ms = min_ms;
        nxt_hr     = hr_now;
        nxt_pm     = pm;
        carry_min  = 1'b1;
        carry_hr   = 1'b0;
        day_roll   = 1'b0;
`ifdef RTC_BCD_COUNTER_SECONDS_EN
        carry_min = 1'b0;
        if (sec_ls_q == 4'd9) begin
            nxt_sec_ls = 4'd0;
            if (sec_ms_q == 4'd5) begin
                nxt_sec_ms = 4'd0;
                carry_min  = 1'b1;
            end else begin
                nxt_sec_ms = sec_ms_q + 4'd1;
            end
        end else begin
            nxt_sec_ls = sec_ls_q + 4'd1;
        end
`endif
        if (carry_min) begin
            if (min_ls == 4'd9) begin
                nxt_min_ls = 4'd0;
                if (min_ms == 4'd5) begin
                    nxt_min_ms = 4'd0;
                    carry_hr   = 1'b1;
                end else begin
                    nxt_min_ms = min_ms + 4'd1;
                end
            end else begin
                nxt_min_ls = min_ls + 4'd1;
            end
        end
        if (carry_hr) begin
            if (mode_r) begin
                day_roll = (hr_now == 5'd23);
                nxt_hr   = day_roll ? 5'd0 : hr_now + 5'd1;
                nxt_pm   = (nxt_hr >= 5'd12);
            end else if (hr_now == 5'd11) begin
                nxt_hr   = 5'd12;
                nxt_pm   = ~pm;
                day_roll = pm;
            end else if (hr_now == 5'd12) begin
                nxt_hr = 5'd1;
            end else begin
                nxt_hr = hr_now + 5'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sec_ls_q   <= 4'd0;
            sec_ms_q   <= 4'd0;
            min_ls     <= 4'd0;
            min_ms     <= 4'd0;
            hr_ls      <= 4'd0;
            hr_ms      <= 4'd0;
            pm         <= 1'b0;
            load_err   <= 1'b0;
            min_pulse  <= 1'b0;
            hour_pulse <= 1'b0;
            day_pulse  <= 1'b0;
            presc      <= '0;
            pending    <= 1'b0;
            mode_r     <= 1'b1;
        end else begin
            load_err   <= 1'b0;
            min_pulse  <= 1'b0;
            hour_pulse <= 1'b0;
            day_pulse  <= 1'b0;
            if (load) begin
                // A load always swallows a coincident tick
                if (ld_ok) begin
`ifdef RTC_BCD_COUNTER_SECONDS_EN
                    sec_ls_q <= load_sec_ls;
                    sec_ms_q <= load_sec_ms;
`endif
                    min_ls  <= load_min_ls;
                    min_ms  <= load_min_ms;
                    hr_ls   <= load_hr_ls;
                    hr_ms   <= load_hr_ms;
                    pm      <= ld_pm;
                    presc   <= '0;
                    pending <= 1'b0;
                end else begin
                    load_err <= 1'b1;
                end
            end else if (mode_24h != mode_r) begin
                mode_r         <= mode_24h;
                {hr_ms, hr_ls} <= bin2bcd(cv_hr);
                pm             <= (to_24h(cv_hr, pm) >= 5'd12) && !mode_r ? 1'b1 :
                                  (mode_r ? (hr_now >= 5'd12) : (cv_hr >= 5'd12));
                presc          <= presc_nxt;
                if (presc_wrap)
                    pending <= 1'b1;
            end else begin
                presc   <= presc_nxt;
                pending <= 1'b0;
                if (pending || presc_wrap) begin
`ifdef RTC_BCD_COUNTER_SECONDS_EN
                    sec_ls_q <= nxt_sec_ls;
                    sec_ms_q <= nxt_sec_ms;
`endif
                    min_ls         <= nxt_min_ls;
                    min_ms         <= nxt_min_ms;
                    {hr_ms, hr_ls} <= bin2bcd(nxt_hr);
                    pm             <= nxt_pm;
                    min_pulse      <= carry_min;
                    hour_pulse     <= carry_hr;
                    day_pulse      <= day_roll;
                end
            end
        end
    end

endmodule

// File: tb/tb_rtc_bcd_counter.sv
// Bench for rtc_bcd_counter: PRESCALE=1 and PRESCALE=4 instances against a seconds-of-day reference model.
module tb_rtc_bcd_counter;
`ifdef RTC_BCD_COUNTER_SECONDS_EN
    localparam bit SEC_EN = 1'b1;
`else
    localparam bit SEC_EN = 1'b0;
`endif
    localparam int UNITS_DAY = SEC_EN ? 86400 : 1440;
    localparam int UPH       = SEC_EN ? 3600 : 60;
    localparam int UPM       = SEC_EN ? 60 : 1;

    logic clk = 1'b0;
    logic reset_n, tick, mode_24h, load, l_pm;
    logic [3:0] l_sec_ls, l_sec_ms, l_min_ls, l_min_ms, l_hr_ls, l_hr_ms;

    logic [3:0] o_sec_ls[2], o_sec_ms[2], o_min_ls[2], o_min_ms[2], o_hr_ls[2], o_hr_ms[2];
    logic       o_pm[2], o_err[2], o_minp[2], o_hrp[2], o_dayp[2];

    int tests = 0;
    int fails = 0;

    // Reference model: time kept as units since midnight; display derived from it
    int m_tod[2], m_presc[2];
    bit m_mode[2], m_pend[2], m_err[2], m_minp[2], m_hrp[2], m_dayp[2];

    always #5 clk = ~clk;

    rtc_bcd_counter #(.PRESCALE(1)) u_p1 (
        .clk(clk), .reset_n(reset_n), .tick(tick), .mode_24h(mode_24h), .load(load),
        .load_sec_ls(l_sec_ls), .load_sec_ms(l_sec_ms), .load_min_ls(l_min_ls),
        .load_min_ms(l_min_ms), .load_hr_ls(l_hr_ls), .load_hr_ms(l_hr_ms), .load_pm(l_pm),
        .sec_ls(o_sec_ls[0]), .sec_ms(o_sec_ms[0]), .min_ls(o_min_ls[0]), .min_ms(o_min_ms[0]),
        .hr_ls(o_hr_ls[0]), .hr_ms(o_hr_ms[0]), .pm(o_pm[0]), .load_err(o_err[0]),
        .min_pulse(o_minp[0]), .hour_pulse(o_hrp[0]), .day_pulse(o_dayp[0])
    );

    rtc_bcd_counter #(.PRESCALE(4)) u_p4 (
        .clk(clk), .reset_n(reset_n), .tick(tick), .mode_24h(mode_24h), .load(load),
        .load_sec_ls(l_sec_ls), .load_sec_ms(l_sec_ms), .load_min_ls(l_min_ls),
        .load_min_ms(l_min_ms), .load_hr_ls(l_hr_ls), .load_hr_ms(l_hr_ms), .load_pm(l_pm),
        .sec_ls(o_sec_ls[1]), .sec_ms(o_sec_ms[1]), .min_ls(o_min_ls[1]), .min_ms(o_min_ms[1]),
        .hr_ls(o_hr_ls[1]), .hr_ms(o_hr_ms[1]), .pm(o_pm[1]), .load_err(o_err[1]),
        .min_pulse(o_minp[1]), .hour_pulse(o_hrp[1]), .day_pulse(o_dayp[1])
    );

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            m_tod[k] = 0; m_presc[k] = 0; m_mode[k] = 1'b1; m_pend[k] = 1'b0;
            m_err[k] = 1'b0; m_minp[k] = 1'b0; m_hrp[k] = 1'b0; m_dayp[k] = 1'b0;
        end
    endfunction

    function automatic void model_clock(int k);
        int ps, hv, mv, sv, h24;
        bit wrap, ok, adv;
        ps = (k == 0) ? 1 : 4;
        m_err[k] = 1'b0; m_minp[k] = 1'b0; m_hrp[k] = 1'b0; m_dayp[k] = 1'b0;
        wrap = tick && (m_presc[k] == ps - 1);
        if (load) begin
            hv = 10 * int'(l_hr_ms) + int'(l_hr_ls);
            mv = 10 * int'(l_min_ms) + int'(l_min_ls);
            sv = 10 * int'(l_sec_ms) + int'(l_sec_ls);
            ok = (l_hr_ms <= 9) && (l_hr_ls <= 9) && (l_min_ms <= 9) && (l_min_ls <= 9) && (mv < 60);
            if (SEC_EN) ok = ok && (l_sec_ms <= 9) && (l_sec_ls <= 9) && (sv < 60);
            ok = ok && (m_mode[k] ? (hv < 24) : (hv >= 1 && hv <= 12));
            if (ok) begin
                h24 = m_mode[k] ? hv : (hv % 12 + (l_pm ? 12 : 0));
                m_tod[k] = h24 * UPH + mv * UPM + (SEC_EN ? sv : 0);
                m_presc[k] = 0;
                m_pend[k] = 1'b0;
            end else begin
                m_err[k] = 1'b1;
            end
        end else if (mode_24h != m_mode[k]) begin
            m_mode[k] = mode_24h;
            if (tick) m_presc[k] = wrap ? 0 : m_presc[k] + 1;
            if (wrap) m_pend[k] = 1'b1;
        end else begin
            adv = m_pend[k] || wrap;
            if (tick) m_presc[k] = wrap ? 0 : m_presc[k] + 1;
            m_pend[k] = 1'b0;
            if (adv) begin
                m_tod[k]  = (m_tod[k] + 1) % UNITS_DAY;
                m_minp[k] = SEC_EN ? (m_tod[k] % 60 == 0) : 1'b1;
                m_hrp[k]  = (m_tod[k] % UPH == 0);
                m_dayp[k] = (m_tod[k] == 0);
            end
        end
    endfunction

    function automatic logic [28:0] model_vec(int k);
        int h24, mn, sc, hd;
        h24 = m_tod[k] / UPH;
        mn  = (m_tod[k] / UPM) % 60;
        sc  = SEC_EN ? m_tod[k] % 60 : 0;
        hd  = m_mode[k] ? h24 : ((h24 % 12 == 0) ? 12 : h24 % 12);
        return {4'(sc / 10), 4'(sc % 10), 4'(mn / 10), 4'(mn % 10), 4'(hd / 10), 4'(hd % 10),
                1'(h24 >= 12), m_err[k], m_minp[k], m_hrp[k], m_dayp[k]};
    endfunction

    function automatic logic [28:0] dut_vec(int k);
        return {o_sec_ms[k], o_sec_ls[k], o_min_ms[k], o_min_ls[k], o_hr_ms[k], o_hr_ls[k],
                o_pm[k], o_err[k], o_minp[k], o_hrp[k], o_dayp[k]};
    endfunction

    task automatic check_all(string tag);
        logic [28:0] got, exp;
        for (int k = 0; k < 2; k++) begin
            got = dut_vec(k);
            exp = model_vec(k);
            tests++;
            assert (got === exp) else begin
                fails++;
                $error("FAIL %s dut%0d {sec,min,hr,pm,err,minp,hrp,dayp}: got %h required %h",
                       tag, k, got, exp);
            end
        end
    endtask

    task automatic cycle(string tag);
        @(posedge clk);
        model_clock(0);
        model_clock(1);
        #1;
        check_all(tag);
    endtask

    task automatic set_load_time(int h24, int mn, int sc, bit is24);
        int hd;
        hd = is24 ? h24 : ((h24 % 12 == 0) ? 12 : h24 % 12);
        l_hr_ms  = 4'(hd / 10); l_hr_ls  = 4'(hd % 10);
        l_min_ms = 4'(mn / 10); l_min_ls = 4'(mn % 10);
        l_sec_ms = 4'(sc / 10); l_sec_ls = 4'(sc % 10);
        l_pm     = (h24 >= 12);
    endtask

    task automatic do_load(string tag);
        load = 1'b1;
        cycle(tag);
        load = 1'b0;
    endtask

    task automatic do_ticks(int n, string tag);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1;
            cycle(tag);
            tick = 1'b0;
            cycle(tag);
        end
    endtask

    initial begin
        int since_mode, h24, mn, sc;
        bit prev_tick;
        reset_n = 1'b0; tick = 1'b0; mode_24h = 1'b1; load = 1'b0;
        set_load_time(0, 0, 0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check_all("reset_state");
        reset_n = 1'b1;

        do_ticks(60, "sixty_ticks");

        // 12-hour noon and midnight rollovers
        mode_24h = 1'b0;
        cycle("to_12h");
        set_load_time(11, 59, 59, 1'b0);
        do_load("load_1159am");
        do_ticks(1, "noon_roll");
        set_load_time(23, 59, 59, 1'b0);
        do_load("load_1159pm");
        do_ticks(1, "midnight_roll_12h");

        mode_24h = 1'b1;
        cycle("to_24h");
        set_load_time(23, 59, 59, 1'b1);
        do_load("load_2359");
        do_ticks(1, "midnight_roll_24h");

        // Rejected loads
        l_hr_ms = 4'd1; l_hr_ls = 4'd2; l_min_ms = 4'd7; l_min_ls = 4'd5;
        l_sec_ms = 4'd0; l_sec_ls = 4'd0;
        do_load("bad_minutes");
        cycle("err_clears");
        mode_24h = 1'b0;
        cycle("to_12h_b");
        set_load_time(13, 0, 0, 1'b1);
        do_load("bad_hour13_12h");
        cycle("err_clears_b");
        set_load_time(0, 0, 0, 1'b1);
        do_load("bad_hour00_12h");
        l_hr_ms = 4'd0; l_hr_ls = 4'd11;
        do_load("bad_digit");

        // Mode change coincident with a wrapping tick holds the advance one cycle
        mode_24h = 1'b1;
        cycle("to_24h_b");
        set_load_time(15, 30, 0, 1'b1);
        do_load("load_1530");
        cycle("idle");
        mode_24h = 1'b0; tick = 1'b1;
        cycle("convert_with_tick");
        tick = 1'b0;
        cycle("pending_drain");
        cycle("after_drain");

        // Prescaler: ticks dropped by a coincident load
        mode_24h = 1'b1;
        cycle("to_24h_c");
        set_load_time(0, 0, 0, 1'b1);
        do_load("load_zero");
        do_ticks(8, "eight_ticks");
        do_ticks(3, "three_ticks");
        set_load_time(1, 2, 3, 1'b1);
        load = 1'b1; tick = 1'b1;
        cycle("load_with_4th_tick");
        load = 1'b0; tick = 1'b0;
        cycle("after_load_tick");
        do_ticks(4, "four_after_load");

        // Asynchronous reset in mid-operation
        tick = 1'b1;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all("async_reset");
        tick = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        check_all("reset_held");

        since_mode = 10;
        prev_tick = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            tick = !prev_tick && ($urandom_range(0, 2) != 0);
            load = 1'b0;
            if (since_mode >= 3 && $urandom_range(0, 39) == 0) begin
                mode_24h = ~mode_24h;
                since_mode = 0;
            end else begin
                since_mode++;
            end
            if (since_mode != 1 && $urandom_range(0, 24) == 0) begin
                load = 1'b1;
                case ($urandom_range(0, 3))
                    0: begin
                        l_hr_ms = 4'($urandom_range(0, 15)); l_hr_ls = 4'($urandom_range(0, 15));
                        l_min_ms = 4'($urandom_range(0, 15)); l_min_ls = 4'($urandom_range(0, 15));
                        l_sec_ms = 4'($urandom_range(0, 15)); l_sec_ls = 4'($urandom_range(0, 15));
                        l_pm = 1'($urandom_range(0, 1));
                    end
                    1: begin
                        h24 = ($urandom_range(0, 1) != 0) ? 23 : 11;
                        set_load_time(h24, 59, int'($urandom_range(55, 59)), m_mode[0]);
                    end
                    default: begin
                        h24 = int'($urandom_range(0, 23));
                        mn  = int'($urandom_range(0, 59));
                        sc  = int'($urandom_range(0, 59));
                        set_load_time(h24, mn, sc, m_mode[0]);
                    end
                endcase
            end
            prev_tick = tick;
            cycle("random");
        end
        tick = 1'b0; load = 1'b0;
        cycle("final");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
